// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM state encoding, timeout fill data and
// word-address helpers used by mem_access_unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & WORD_ADDR_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready port between the MEM stage (master) and memory (slave).
interface mem_access_unit_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ready
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ready
    );

endinterface

// File: rtl/mem_access_unit_hilo_reg.sv
// HI/LO register pair loaded from the 64-bit divider result {hi,lo}.
module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [63:0] din,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we) begin
            hi_q <= din[63:32];
            lo_q <= din[31:0];
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: load/store sequencing on a req/ready port with pipeline stall and
// timeout abort, branch resolution and HI/LO. Optional MEM_MISALIGN_TRAP_EN adds misalign.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              store_data,
    input  logic                     is_branch,
    input  logic                     zero,
    input  logic [31:0]              branch_pc,
    input  logic [63:0]              divd,
    input  logic                     open_hilo,
    mem_access_unit_if.master        dm,
    output logic                     stall,
    output logic [31:0]              mem_data,
    output logic                     pc_src,
    output logic [31:0]              branch_target,
    output logic [31:0]              hi,
    output logic [31:0]              lo,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                     misalign,
`endif
    output logic                     bus_err
);

    state_e             state_q;
    logic               req_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bus_err_q;
    logic               access;
    logic               trap;
    logic               issue;
    logic               timeout_hit;

    assign access = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap     = access & is_misaligned(alu_result);
    assign misalign = misalign_q;
`else
    assign trap = 1'b0;
`endif

    assign issue       = (state_q == ST_IDLE) & access & ~trap;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Gated by rst so the pipeline is released the instant reset asserts,
    // even while the frozen EX/MEM register still presents a memory op.
    assign stall = ~rst & (issue | (state_q == ST_BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= (state_q == ST_IDLE) & trap;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= word_addr(alu_result);
                        wdata_q <= store_data;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dm.dm_ready) begin
                        if (!we_q) begin
                            mem_data_q <= dm.dm_rdata;
                        end
                        req_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        req_q      <= 1'b0;
                        bus_err_q  <= 1'b1;
                        mem_data_q <= TIMEOUT_DATA;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;

    assign mem_data = mem_data_q;
    assign bus_err  = bus_err_q;

    assign pc_src        = is_branch & zero;
    assign branch_target = branch_pc;

    hilo_reg u_hilo_reg (
        .clk (clk),
        .rst (rst),
        .we  (open_hilo & ~stall),
        .din (divd),
        .hi  (hi),
        .lo  (lo)
    );

endmodule
